// File: rtl/led_pkg.sv
// ============================================================================
// Module : led_pkg
// Shared command/state encodings and duty width for the LED sequencers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_pkg;

  localparam int LED_DC_W = 8;

  typedef enum logic [1:0] {
    MODE_SET     = 2'b00,
    MODE_FADE    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_STOP    = 2'b11
  } ledMode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FADE    = 2'b01,
    ST_BR_UP   = 2'b10,
    ST_BR_DOWN = 2'b11
  } ledState_t;

endpackage

`default_nettype wire

// File: rtl/led_step_timer.sv
// ============================================================================
// Module : led_step_timer
// Free-running step divider; Tick on the last count of each Div interval.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_step_timer
  import led_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic [DIV_W-1:0] Div,
  output logic             Tick
);

  logic [DIV_W-1:0] w_divEff;
  logic [DIV_W-1:0] r_count;

  // A zero divider behaves as one step per clock
  assign w_divEff = (Div == '0) ? DIV_W'(1) : Div;
  assign Tick     = (r_count >= (w_divEff - DIV_W'(1)));

  always_ff @(posedge SysClk) begin
    if (Reset || Clear) begin
      r_count <= '0;
    end else if (Tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_fade_ctrl.sv
// ============================================================================
// Module : led_fade_ctrl
// Duty sequencer (set / fade / breathe / stop) feeding the PWM LED stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_fade_ctrl
  import led_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int DC_W  = LED_DC_W
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdMode,
  input  logic [DC_W-1:0]  CmdTarget,
  input  logic [DC_W-1:0]  CmdLow,
  input  logic [DIV_W-1:0] CmdStepDiv,
  output logic [DC_W-1:0]  DutyCycle,
  output logic             Busy,
  output logic             Done
);

  ledState_t        r_state;
  logic [DC_W-1:0]  r_duty;
  logic [DC_W-1:0]  r_target;
  logic [DC_W-1:0]  r_lo;
  logic [DC_W-1:0]  r_hi;
  logic [DIV_W-1:0] r_div;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_tick;
  ledMode_t         w_mode;
  logic [DC_W-1:0]  w_lo;
  logic [DC_W-1:0]  w_hi;

  // A running fade is not interruptible; breathe may be replaced at any time
  assign CmdReady = (r_state != ST_FADE);
  assign w_accept = CmdValid && CmdReady;
  assign w_mode   = ledMode_t'(CmdMode);
  assign w_lo     = (CmdTarget < CmdLow) ? CmdTarget : CmdLow;
  assign w_hi     = (CmdTarget < CmdLow) ? CmdLow : CmdTarget;

  led_step_timer #(
    .DIV_W (DIV_W)
  ) u_stepTimer (
    .SysClk (SysClk),
    .Reset  (Reset),
    .Clear  (w_accept),
    .Div    (r_div),
    .Tick   (w_tick)
  );

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_div    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_div <= CmdStepDiv;
        case (w_mode)
          MODE_SET: begin
            r_duty  <= CmdTarget;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          MODE_FADE: begin
            r_target <= CmdTarget;
            if (CmdTarget == r_duty) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_FADE;
              r_busy  <= 1'b1;
            end
          end
          MODE_BREATHE: begin
            r_lo    <= w_lo;
            r_hi    <= w_hi;
            r_duty  <= w_lo;
            r_state <= ST_BR_UP;
            r_busy  <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          ST_FADE: begin
            // Arrival is detected one cycle after the final step, giving Done at N*div+1
            if (r_duty == r_target) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_tick) begin
              r_duty <= (r_duty < r_target) ? r_duty + DC_W'(1) : r_duty - DC_W'(1);
            end
          end
          ST_BR_UP: begin
            if (w_tick) begin
              if (r_duty < r_hi) begin
                r_duty <= r_duty + DC_W'(1);
              end else begin
                r_state <= ST_BR_DOWN;
                if (r_duty > r_lo) r_duty <= r_duty - DC_W'(1);
              end
            end
          end
          ST_BR_DOWN: begin
            if (w_tick) begin
              if (r_duty > r_lo) begin
                r_duty <= r_duty - DC_W'(1);
              end else begin
                r_state <= ST_BR_UP;
                if (r_duty < r_hi) r_duty <= r_duty + DC_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign DutyCycle = r_duty;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
// ============================================================================
// Module : tb_led_fade_ctrl
// Directed scoreboard bench for led_fade_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_fade_ctrl;

  localparam int DIV_W = 16;
  localparam int DC_W  = 8;

  logic             SysClk = 1'b0;
  logic             Reset;
  logic             CmdValid;
  logic             CmdReady;
  logic [1:0]       CmdMode;
  logic [DC_W-1:0]  CmdTarget;
  logic [DC_W-1:0]  CmdLow;
  logic [DIV_W-1:0] CmdStepDiv;
  logic [DC_W-1:0]  DutyCycle;
  logic             Busy;
  logic             Done;

  typedef struct {
    string tag;
    int    val;
  } expEntry_t;

  expEntry_t expQ[$];
  int total = 0;
  int bad   = 0;

  led_fade_ctrl #(
    .DIV_W (DIV_W),
    .DC_W  (DC_W)
  ) dut (
    .SysClk     (SysClk),
    .Reset      (Reset),
    .CmdValid   (CmdValid),
    .CmdReady   (CmdReady),
    .CmdMode    (CmdMode),
    .CmdTarget  (CmdTarget),
    .CmdLow     (CmdLow),
    .CmdStepDiv (CmdStepDiv),
    .DutyCycle  (DutyCycle),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 SysClk = ~SysClk;

  task automatic tick();
    @(posedge SysClk);
    #1;
  endtask

  task automatic pushExp(input string tag, input int val);
    expEntry_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input int obs);
    expEntry_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Push expected duty/done/busy/ready, then compare against the DUT
  task automatic expectAll(input string tag, input int duty, input int dn, input int bs, input int rdy);
    pushExp({tag, "_duty"}, duty);
    pushExp({tag, "_done"}, dn);
    pushExp({tag, "_busy"}, bs);
    pushExp({tag, "_ready"}, rdy);
    popCheck(int'(DutyCycle));
    popCheck(int'(Done));
    popCheck(int'(Busy));
    popCheck(int'(CmdReady));
  endtask

  task automatic sendCmd(input logic [1:0] mode, input int tgt, input int lo, input int dv);
    CmdValid   = 1'b1;
    CmdMode    = mode;
    CmdTarget  = DC_W'(tgt);
    CmdLow     = DC_W'(lo);
    CmdStepDiv = DIV_W'(dv);
    tick();
    CmdValid   = 1'b0;
  endtask

  function automatic int breatheVal(input int k);
    int seq[4];
    seq = '{3, 4, 5, 4};
    return seq[(k / 2) % 4];
  endfunction

  initial begin
    Reset = 1'b1;
    CmdValid = 1'b1;
    CmdMode = 2'b00;
    CmdTarget = 8'd200;
    CmdLow = '0;
    CmdStepDiv = 16'd1;

    // Reset held 3 cycles with a SET pending
    tick(); tick(); tick();
    expectAll("in_reset", 0, 0, 0, 1);
    Reset = 1'b0;
    CmdValid = 1'b0;
    tick();
    expectAll("post_reset", 0, 0, 0, 1);

    // SET 128
    sendCmd(2'b00, 128, 0, 5);
    expectAll("set128", 128, 1, 0, 1);
    tick();
    expectAll("set128_after", 128, 0, 0, 1);

    // FADE 10 -> 14, div 3, with a SET held valid mid-fade
    sendCmd(2'b00, 10, 0, 1);
    sendCmd(2'b01, 14, 0, 3);
    expectAll("fade_k0", 10, 0, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) begin
        CmdValid = 1'b1; CmdMode = 2'b00; CmdTarget = 8'd50; CmdStepDiv = 16'd1;
      end
      tick();
      expectAll($sformatf("fade_k%0d", k),
                (k == 14) ? 50 : ((10 + k / 3) > 14 ? 14 : 10 + k / 3),
                (k >= 13) ? 1 : 0,
                (k <= 12) ? 1 : 0,
                (k <= 12) ? 0 : 1);
      if (k == 14) CmdValid = 1'b0;
    end

    // FADE to 0 from 2, div 0 (one step per clock)
    sendCmd(2'b00, 2, 0, 1);
    sendCmd(2'b01, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      expectAll($sformatf("fade0_k%0d", k), (k >= 2) ? 0 : 1, (k == 3) ? 1 : 0,
                (k <= 2) ? 1 : 0, (k <= 2) ? 0 : 1);
    end

    // FADE to current value
    sendCmd(2'b01, 0, 0, 4);
    expectAll("fade_same", 0, 1, 0, 1);

    // BREATHE 5/3 div 2, then STOP at 4
    sendCmd(2'b10, 5, 3, 2);
    expectAll("br_k0", 3, 0, 1, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      expectAll($sformatf("br_k%0d", k), breatheVal(k), 0, 1, 1);
    end
    sendCmd(2'b11, 0, 0, 1);
    expectAll("stop", 4, 0, 0, 1);
    tick(); tick(); tick();
    expectAll("stop_hold", 4, 0, 0, 1);

    // STOP while idle is harmless
    sendCmd(2'b11, 0, 0, 1);
    expectAll("stop_idle", 4, 0, 0, 1);

    // Reset mid-BREATHE at duty 4
    sendCmd(2'b10, 3, 5, 2);
    tick(); tick();
    expectAll("br2_k2", 4, 0, 1, 1);
    Reset = 1'b1;
    tick();
    expectAll("mid_reset", 0, 0, 0, 1);
    Reset = 1'b0;

    // Degenerate breathe holds its single value
    sendCmd(2'b10, 7, 7, 1);
    for (int k = 0; k < 8; k++) begin
      expectAll($sformatf("br7_k%0d", k), 7, 0, 1, 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_fade_ctrl.md
Name: led_fade_ctrl

Overview:
Brightness sequencer that sits directly upstream of the 8-bit PWM LED generator. It produces the DutyCycle value that the PWM stage consumes.
It accepts commands over a valid/ready handshake: immediate set, linear fade to a target, triangle "breathe" between two bounds, and stop.
Duty changes move one LSB per programmable step interval, so the LED ramps smoothly instead of jumping.

Parameters:
DIV_W, 16, width of the step-interval divider (clocks per duty step).
DC_W, 8, duty width; must match the PWM stage's DutyCycle input.

Ports:
SysClk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
CmdValid  in  1  command present
CmdReady  out  1  block can accept a command this cycle
CmdMode  in  2  00 SET, 01 FADE, 10 BREATHE, 11 STOP
CmdTarget  in  DC_W  SET/FADE target; BREATHE bound A
CmdLow  in  DC_W  BREATHE bound B; ignored by other modes
CmdStepDiv  in  DIV_W  clocks per duty step; 0 is treated as 1
DutyCycle  out  DC_W  registered duty value driving the PWM stage
Busy  out  1  high whenever the state is not IDLE
Done  out  1  one-cycle pulse on SET completion or FADE arrival

Behaviour:
- Clock and reset: SysClk drives all logic. Reset is synchronous, active-high, and dominates every other input. Reset takes effect mid-operation with no cleanup.
- Reset values: DutyCycle=0, state IDLE, Busy=0, Done=0, step counter=0, direction=up. CmdValid is ignored while Reset is high.
- States: IDLE, FADE, BR_UP, BR_DOWN. All are registered.
- CmdReady: combinational from state. It is 1 in IDLE, BR_UP and BR_DOWN, and 0 in FADE, so a fade cannot be interrupted. A command is accepted on a rising edge where CmdValid and CmdReady are both 1.
- Every accepted command clears the step counter and latches div = max(CmdStepDiv, 1).
- Step tick: the step counter counts 0..div-1. The tick is asserted in the cycle the counter equals div-1, and the counter wraps to 0. The first tick therefore occurs div cycles after acceptance.
- SET: DutyCycle=CmdTarget on the cycle after acceptance, Done=1 for that cycle, state goes to IDLE.
- FADE, target equal to the current duty: Done pulses the next cycle and the state stays or becomes IDLE.
- FADE, otherwise: enter FADE. On each tick DutyCycle moves +1 or -1 toward the target.
  - On the tick where DutyCycle reaches the target, Done pulses in the following cycle and the state goes to IDLE.
  - A fade of N LSB completes in N*div cycles after acceptance (Done at N*div+1).
- BREATHE: lo=min(CmdTarget,CmdLow), hi=max(CmdTarget,CmdLow). DutyCycle is loaded with lo on the cycle after acceptance and the state becomes BR_UP.
  - BR_UP tick: if DutyCycle<hi then +1, else go to BR_DOWN and -1.
  - BR_DOWN tick: if DutyCycle>lo then -1, else go to BR_UP and +1.
  - If lo==hi, DutyCycle holds at lo and the state alternates with no value change.
  - Period is 2*(hi-lo)*div cycles. Each endpoint is visible for exactly one step.
- STOP: state goes to IDLE and DutyCycle freezes at its current value. There is no Done pulse. STOP in IDLE is accepted and has no effect.
- New command during breathe: any accepted command replaces the breathe immediately (the same edge exits BR_*).
- Arithmetic: DutyCycle never wraps. The +1/-1 steps are bounded by the target or bounds, so 0 and 255 are reachable but never overrun.
- Done and Busy are registered. Busy is 1 for the whole FADE and breathe duration, and 0 in the cycle that Done is high.

Decomposition:
- Shared package led_pkg holds:
  - CmdMode encodings (MODE_SET, MODE_FADE, MODE_BREATHE, MODE_STOP)
  - the state encoding
  - the DC_W default, shared with the PWM stage.
- Sub-module led_step_timer (SysClk, Reset, Clear, Div, Tick) holds the divider counter with max(Div,1) handling. It is reusable by other LED sequencers.

Test Plan:
- Reset: hold Reset 3 cycles while CmdValid=1 with SET 200 -> DutyCycle=0, Busy=0, CmdReady=1 the cycle after Reset falls, and the command is not taken.
- SET 128, div=5 -> DutyCycle=128 and Done=1 exactly one cycle after acceptance; Busy stays 0.
- FADE from 10 to 14, div=3:
  - DutyCycle steps 11,12,13,14 at cycles 3,6,9,12 after acceptance.
  - Done at cycle 13.
  - CmdReady=0 throughout, and a SET held valid mid-fade is accepted only after IDLE.
- FADE to 0 from 2 with CmdStepDiv=0 -> one step per clock, no wrap below 0, Done after 3 cycles. FADE to the current value -> Done next cycle.
- BREATHE CmdTarget=5, CmdLow=3, div=2 -> DutyCycle 3,4,5,4,3,4,... changing every 2 cycles; STOP at value 4 freezes 4 with Busy=0.
- Reset asserted mid-BREATHE at duty 4 -> next cycle DutyCycle=0, state IDLE, Done=0; BREATHE with CmdTarget=CmdLow=7 holds 7 indefinitely.
